bht_ctrl: RTL and testbench

Branch history table controller for the RISC-V pipeline. Owns an array of 2-bit saturating prediction counters indexed by PC, serves one prediction lookup per cycle from fetch, and sequences read-modify-write updates from execute through the shared 2-bit saturating counter next-state logic. Also runs the table initialisation sweep after reset and on flush.

---
 rtl/bht_pkg.sv | 13 +
 rtl/two_bit_sat_counter.sv | 18 +
 rtl/bht_ctrl.sv | 111 +++++++++++
 tb/tb_bht_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// bht_pkg: shared constants for the branch history table controller.
//   Counter encodings SNT/WNT/WT/ST, default sweep value, FSM state encodings.
package bht_pkg;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] DEF_INIT_VAL = WNT;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/two_bit_sat_counter.sv
// two_bit_sat_counter: next-state of a 2-bit prediction counter.
//   count_i in 2 : current counter value
//   op      in 1 : 1 = prediction was correct, 0 = mispredicted
//   count   out 2: next counter value
module two_bit_sat_counter
    import bht_pkg::*;
(
    input  logic [1:0] count_i,
    input  logic       op,
    output logic [1:0] count
);
    // Correct pushes weak states to their strong side; a miss steps toward
    // the opposite half, so 01 and 10 bounce between each other.
    always_comb begin
        count = op ? ((count_i == WNT) ? SNT : (count_i == WT) ? ST : count_i)
                   : (count_i[1] ? count_i - 2'd1 : count_i + 2'd1);
    end
endmodule

// File: rtl/bht_ctrl.sv
// bht_ctrl: branch history table of 2-bit counters with lookup and RMW update.
//   clk, rst_n (sync, active-low), flush_i restarts the init sweep.
//   lkp_valid_i/lkp_pc_i -> lkp_valid_o/lkp_taken_o one cycle later.
//   upd_valid_i/upd_pc_i/upd_correct_i, accepted when upd_ready_o is high.
//   busy_o high while the init sweep runs.
//   Define BHT_LKP_BYPASS_EN to let a lookup see a same-cycle matching write.
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int unsigned ENTRIES  = 64,
    parameter logic [1:0]  INIT_VAL = DEF_INIT_VAL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush_i,
    input  logic        lkp_valid_i,
    input  logic [31:0] lkp_pc_i,
    output logic        lkp_valid_o,
    output logic        lkp_taken_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_correct_i,
    output logic        upd_ready_o,
    output logic        busy_o
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    logic [1:0]       table_q [ENTRIES];
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             lkp_valid_q, lkp_valid_d;
    logic             lkp_taken_q, lkp_taken_d;
    logic             s2_valid_q, s2_valid_d;
    logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
    logic [1:0]       s2_old_q, s2_old_d;
    logic             s2_op_q, s2_op_d;

    logic             run;
    logic             s2_we;
    logic [IDX_W-1:0] lkp_idx, upd_idx;
    logic [1:0]       s2_next, s1_cnt, lkp_cnt;
    logic             unused_pc;

    assign unused_pc = ^{lkp_pc_i[31:IDX_W+2], lkp_pc_i[1:0],
                         upd_pc_i[31:IDX_W+2], upd_pc_i[1:0]};

    two_bit_sat_counter u_sat (
        .count_i (s2_old_q),
        .op      (s2_op_q),
        .count   (s2_next)
    );

    always_comb begin
        run     = (state_q == ST_RUN);
        lkp_idx = lkp_pc_i[IDX_W+1:2];
        upd_idx = upd_pc_i[IDX_W+1:2];
        // A flush discards the write still sitting in S2.
        s2_we   = s2_valid_q & ~flush_i;
        // Back-to-back updates to one entry must chain through the pending result.
        s1_cnt  = (s2_valid_q && s2_idx_q == upd_idx) ? s2_next : table_q[upd_idx];
`ifdef BHT_LKP_BYPASS_EN
        lkp_cnt = (s2_we && s2_idx_q == lkp_idx) ? s2_next : table_q[lkp_idx];
`else
        lkp_cnt = table_q[lkp_idx];
`endif
        state_d     = flush_i ? ST_INIT
                    : (!run && sweep_q == IDX_W'(ENTRIES - 1)) ? ST_RUN : state_q;
        sweep_d     = flush_i ? '0 : run ? sweep_q : sweep_q + IDX_W'(1);
        lkp_valid_d = lkp_valid_i & run;
        lkp_taken_d = lkp_valid_d ? lkp_cnt[1] : lkp_taken_q;
        s2_valid_d  = upd_valid_i & run & ~flush_i;
        s2_idx_d    = upd_idx;
        s2_old_d    = s1_cnt;
        s2_op_d     = upd_correct_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            lkp_valid_q <= 1'b0;
            lkp_taken_q <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_idx_q    <= '0;
            s2_old_q    <= '0;
            s2_op_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            lkp_valid_q <= lkp_valid_d;
            lkp_taken_q <= lkp_taken_d;
            s2_valid_q  <= s2_valid_d;
            s2_idx_q    <= s2_idx_d;
            s2_old_q    <= s2_old_d;
            s2_op_q     <= s2_op_d;
        end
    end

    // No reset on the array; the sweep establishes every entry.
    always_ff @(posedge clk) begin
        if (!run)
            table_q[sweep_q] <= INIT_VAL;
        else if (s2_we)
            table_q[s2_idx_q] <= s2_next;
    end

    assign lkp_valid_o = lkp_valid_q;
    assign lkp_taken_o = lkp_taken_q;
    assign upd_ready_o = run;
    assign busy_o      = ~run;
endmodule

// File: tb/tb_bht_ctrl.sv
// tb_bht_ctrl: randomized and directed checks of bht_ctrl against a table model.
module tb_bht_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic        lkp_valid_i = 1'b0;
    logic [31:0] lkp_pc_i = '0;
    logic        lkp_valid_o, lkp_taken_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_correct_i = 1'b0;
    logic        upd_ready_o, busy_o;

    bht_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush_i),
        .lkp_valid_i   (lkp_valid_i),
        .lkp_pc_i      (lkp_pc_i),
        .lkp_valid_o   (lkp_valid_o),
        .lkp_taken_o   (lkp_taken_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_correct_i (upd_correct_i),
        .upd_ready_o   (upd_ready_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [1:0] val;
        int         cyc;
    } pend_t;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         init_left;
    logic       exp_v, exp_t;
    logic [1:0] lt [64];
    logic [1:0] tt [64];
    logic [1:0] inc_tab [4];
    logic [1:0] cor_tab [4];
    pend_t      pend [$];

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic logic [31:0] rpc();
        int i;
        i = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 3);
        return ($urandom & 32'hFFFF_FF03) | (32'(i) << 2);
    endfunction

    task automatic model_init();
        foreach (lt[i]) begin
            lt[i] = 2'b01;
            tt[i] = 2'b01;
        end
        pend.delete();
        init_left = 64;
    endtask

    // Called at a falling edge: checks last cycle's results, then drives one cycle.
    task automatic step(input logic lv, input logic [31:0] lpc, input logic uv,
                        input logic [31:0] upc, input logic uc, input logic fl);
        bit run;
        chk("busy", busy_o, init_left > 0);
        chk("ready", upd_ready_o, init_left == 0);
        chk("lkp_valid", lkp_valid_o, exp_v);
        chk("lkp_taken", lkp_taken_o, exp_t);
        lkp_valid_i = lv;  lkp_pc_i = lpc;
        upd_valid_i = uv;  upd_pc_i = upc;  upd_correct_i = uc;
        flush_i = fl;
        run = (init_left == 0);
        // Updates accepted two or more cycles ago are now in the table.
        while (pend.size() > 0 && pend[0].cyc <= cyc - 2) begin
            tt[pend[0].idx] = pend[0].val;
            void'(pend.pop_front());
        end
        exp_v = lv && run;
        if (exp_v) begin
`ifdef BHT_LKP_BYPASS_EN
            exp_t = lt[idx_of(lpc)][1];
`else
            exp_t = tt[idx_of(lpc)][1];
`endif
        end
        if (fl) begin
            model_init();
        end else begin
            if (uv && run) begin
                lt[idx_of(upc)] = uc ? cor_tab[lt[idx_of(upc)]] : inc_tab[lt[idx_of(upc)]];
                pend.push_back('{idx_of(upc), lt[idx_of(upc)], cyc});
            end
            if (!run) init_left--;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic c);
        step(1'b0, '0, 1'b1, pc, c, 1'b0);
    endtask

    task automatic lkp(input logic [31:0] pc);
        step(1'b1, pc, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        inc_tab = '{2'b01, 2'b10, 2'b01, 2'b10};
        cor_tab = '{2'b00, 2'b00, 2'b11, 2'b11};
        model_init();
        exp_v = 1'b0;
        exp_t = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        idle(64);
        lkp(32'h0000_1234);
        idle(1);

        upd(32'h100, 1'b0);
        upd(32'h100, 1'b0);
        idle(1);
        upd(32'h100, 1'b0);
        idle(1);
        lkp(32'h100);
        idle(1);

        upd(32'h40, 1'b0);
        upd(32'h40, 1'b0);
        idle(2);
        lkp(32'h40);
        idle(1);

        upd(32'h80, 1'b0);
        upd(32'h80, 1'b1);
        upd(32'h80, 1'b1);
        idle(2);
        lkp(32'h80);
        repeat (3) upd(32'h80, 1'b0);
        idle(2);
        lkp(32'h80);
        idle(1);

        upd(32'h200, 1'b0);
        lkp(32'h200);
        idle(1);

        upd(32'h100, 1'b0);
        step(1'b0, '0, 1'b1, 32'h100, 1'b0, 1'b1);
        idle(64);
        lkp(32'h100);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            logic fl, lv;
            fl = ($urandom_range(0, 399) == 0);
            lv = $urandom_range(0, 1) == 1 && !fl;
            step(lv, rpc(), $urandom_range(0, 3) != 0, rpc(), $urandom_range(0, 1) == 1, fl);
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
